// File: rtl/gic_arbiter.sv
// Round-robin Wishbone arbiter in front of the single GIC master link.
// One grant per bus cycle, idle cycle between transactions, timeout abort.
module gic_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_n_i,
    input  logic [NUM_MASTERS-1:0]    m_cyc_i,
    input  logic [NUM_MASTERS-1:0]    m_stb_i,
    input  logic [NUM_MASTERS-1:0]    m_we_i,
    input  logic [4*NUM_MASTERS-1:0]  m_sel_i,
    input  logic [32*NUM_MASTERS-1:0] m_adr_i,
    input  logic [32*NUM_MASTERS-1:0] m_dat_i,
    output logic [31:0]               m_dat_o,
    output logic [NUM_MASTERS-1:0]    m_ack_o,
    output logic [NUM_MASTERS-1:0]    m_err_o,
    output logic [NUM_MASTERS-1:0]    m_rty_o,
    output logic                      s_cyc_o,
    output logic                      s_stb_o,
    output logic                      s_we_o,
    output logic [3:0]                s_sel_o,
    output logic [31:0]               s_adr_o,
    output logic [31:0]               s_dat_o,
    output logic [2:0]                s_cti_o,
    output logic [1:0]                s_bte_o,
    input  logic [31:0]               s_dat_i,
    input  logic                      s_ack_i,
    input  logic                      s_err_i,
    input  logic                      s_rty_i,
    output logic [NUM_MASTERS-1:0]    grant_o
);

    localparam int LW = $clog2(NUM_MASTERS);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_e;

    state_e                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [LW-1:0]          last_q, last_d;
    logic [CW-1:0]          cnt_q, cnt_d;

    logic [NUM_MASTERS-1:0] req;
    logic                   g_cyc, g_stb, done, tmo, found;
    int                     idx;

    assign req     = m_cyc_i & m_stb_i;
    assign g_cyc   = |(m_cyc_i & grant_q);
    assign g_stb   = |(m_stb_i & grant_q);
    assign done    = s_ack_i | s_err_i | s_rty_i;
    assign tmo     = (cnt_q == CNT_LAST);
    assign m_dat_o = s_dat_i;
    assign s_cti_o = 3'b000;
    assign s_bte_o = 2'b00;
    assign grant_o = grant_q;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= LW'(NUM_MASTERS - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        found   = 1'b0;
        idx     = 0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        m_rty_o = '0;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    // Search starts just after the last winner and wraps.
                    for (int i = 1; i <= NUM_MASTERS; i++) begin
                        idx = (int'(last_q) + i) % NUM_MASTERS;
                        if (!found && req[idx]) begin
                            found        = 1'b1;
                            grant_d      = '0;
                            grant_d[idx] = 1'b1;
                            last_d       = LW'(idx);
                        end
                    end
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                for (int k = 0; k < NUM_MASTERS; k++) begin
                    if (grant_q[k]) begin
                        s_we_o  = m_we_i[k];
                        s_sel_o = m_sel_i[4*k +: 4];
                        s_adr_o = m_adr_i[32*k +: 32];
                        s_dat_o = m_dat_i[32*k +: 32];
                    end
                end
                if (!g_cyc) begin
                    state_d = DRAIN;
                    grant_d = '0;
                    cnt_d   = '0;
                end else if (done) begin
                    s_cyc_o = 1'b1;
                    s_stb_o = g_stb;
                    m_ack_o = grant_q & {NUM_MASTERS{s_ack_i}};
                    m_err_o = grant_q & {NUM_MASTERS{s_err_i}};
                    m_rty_o = grant_q & {NUM_MASTERS{s_rty_i}};
                    state_d = DRAIN;
                    grant_d = '0;
                    cnt_d   = '0;
                end else if (tmo) begin
                    // Dead link: cut the cycle and fail the master.
                    m_err_o = grant_q;
                    state_d = DRAIN;
                    grant_d = '0;
                    cnt_d   = '0;
                end else begin
                    s_cyc_o = 1'b1;
                    s_stb_o = g_stb;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                grant_d = '0;
                state_d = IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

endmodule
